// File: rtl/latrnq_bank_pkg.sv
// Shared types and constants for the latrnq_bank multi-channel holding bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package latrnq_bank_pkg;

    // Commit handshake FSM: IDLE accepts commits, HOLD is the cool-down window.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic MODE_STAGED      = 1'b0;
    localparam logic MODE_TRANSPARENT = 1'b1;

endpackage

// File: rtl/latrnq_bank_chan.sv
// One bank channel: staging register, published register, dirty flag, optional parity.
// Latency: staged write -> dirty 1 cycle; transparent write or commit -> Q 1 cycle.
// Backpressure: none; writes always accepted, commit pulse is pre-qualified by the top.
// Optional feature macro: LATRNQ_BANK_PARITY_EN (adds registered even parity of Q).
module latrnq_bank_chan
    import latrnq_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    input  logic             e_i,
    input  logic             mode_i,
    input  logic             commit_i,
    output logic [WIDTH-1:0] q_o,
    output logic             dirty_o
`ifdef LATRNQ_BANK_PARITY_EN
    ,
    output logic             qp_o
`endif
);

    logic [WIDTH-1:0] stg_q, stg_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dirty_q, dirty_d;
    logic             load;
    logic [WIDTH-1:0] load_val;

    // Next-state: a commit publishes dirty or same-cycle-written data (write forwarded),
    // a transparent write publishes directly; a commit only arrives in staged mode.
    always_comb begin
        stg_d    = stg_q;
        q_d      = q_q;
        dirty_d  = dirty_q;
        load_val = e_i ? d_i : stg_q;
        if (commit_i) begin
            load = dirty_q | e_i;
        end else begin
            load = e_i & (mode_i == MODE_TRANSPARENT);
        end
        if (e_i) begin
            stg_d = d_i;
        end
        if (load) begin
            q_d = load_val;
        end
        if (commit_i) begin
            dirty_d = 1'b0;
        end else if (e_i) begin
            dirty_d = (mode_i == MODE_STAGED);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_q   <= '0;
            q_q     <= '0;
            dirty_q <= 1'b0;
        end else begin
            stg_q   <= stg_d;
            q_q     <= q_d;
            dirty_q <= dirty_d;
        end
    end

    assign q_o     = q_q;
    assign dirty_o = dirty_q;

`ifdef LATRNQ_BANK_PARITY_EN
    logic qp_q;

    // Parity tracks exactly the value loaded into Q, on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            qp_q <= 1'b0;
        end else if (load) begin
            qp_q <= ^load_val;
        end
    end

    assign qp_o = qp_q;
`endif

endmodule

// File: rtl/latrnq_bank.sv
// Multi-channel data-holding bank: per-channel staging, atomic commit publish, transparent mode.
// Latency: writes and commits visible on outputs 1 cycle after the capturing edge.
// Backpressure: COMMIT_READY drops for HOLDOFF cycles after each accepted commit; writes never stall.
// Optional feature macro: LATRNQ_BANK_PARITY_EN (adds QP output).
module latrnq_bank
    import latrnq_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int HOLDOFF  = 2
) (
    input  logic                      CLK,
    input  logic                      RN,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [CHANNELS-1:0]       E,
    input  logic                      MODE,
    input  logic                      COMMIT_VALID,
    output logic                      COMMIT_READY,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       DIRTY
`ifdef LATRNQ_BANK_PARITY_EN
    ,
    output logic [CHANNELS-1:0]       QP
`endif
);

    localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            handshake;
    logic            commit;

    // Ready depends only on the state register, so the handshake has no output-to-input loop.
    assign handshake = COMMIT_VALID & (state_q == IDLE);
    // In transparent mode the handshake still runs the cool-down but moves no data.
    assign commit    = handshake & (MODE == MODE_STAGED);

    // FSM next-state and ready decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        COMMIT_READY = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (handshake && (HOLDOFF > 0)) begin
                    state_d = HOLD;
                    cnt_d   = CNT_LOAD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and cool-down counter registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        latrnq_bank_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_i    (CLK),
            .rst_ni   (RN),
            .d_i      (D[i*WIDTH +: WIDTH]),
            .e_i      (E[i]),
            .mode_i   (MODE),
            .commit_i (commit),
            .q_o      (Q[i*WIDTH +: WIDTH]),
            .dirty_o  (DIRTY[i])
`ifdef LATRNQ_BANK_PARITY_EN
            ,
            .qp_o     (QP[i])
`endif
        );
    end

endmodule

// File: tb/tb_latrnq_bank.sv
// Self-checking bench for latrnq_bank: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_latrnq_bank;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int NB = CH * W;

    logic          CLK = 1'b0;
    logic          RN;
    logic [NB-1:0] D;
    logic [CH-1:0] E;
    logic          MODE;
    logic          CV;

    logic          rdy_a, rdy_b;
    logic [NB-1:0] q_a, q_b;
    logic [CH-1:0] dirty_a, dirty_b;
`ifdef LATRNQ_BANK_PARITY_EN
    logic [CH-1:0] qp_a, qp_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    latrnq_bank #(.WIDTH(W), .CHANNELS(CH), .HOLDOFF(2)) dut (
        .CLK(CLK), .RN(RN), .D(D), .E(E), .MODE(MODE), .COMMIT_VALID(CV),
        .COMMIT_READY(rdy_a), .Q(q_a), .DIRTY(dirty_a)
`ifdef LATRNQ_BANK_PARITY_EN
        , .QP(qp_a)
`endif
    );

    latrnq_bank #(.WIDTH(W), .CHANNELS(CH), .HOLDOFF(0)) dut0 (
        .CLK(CLK), .RN(RN), .D(D), .E(E), .MODE(MODE), .COMMIT_VALID(CV),
        .COMMIT_READY(rdy_b), .Q(q_b), .DIRTY(dirty_b)
`ifdef LATRNQ_BANK_PARITY_EN
        , .QP(qp_b)
`endif
    );

    // Reference model: index 0 tracks dut (HOLDOFF=2), index 1 tracks dut0 (HOLDOFF=0).
    logic [W-1:0] m_stg  [2][CH];
    logic [W-1:0] m_q    [2][CH];
    logic         m_dirty[2][CH];
    logic         m_qp   [2][CH];
    int           m_hold [2];
    int           m_holdoff[2] = '{2, 0};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 0;
            for (int c = 0; c < CH; c++) begin
                m_stg[k][c] = '0; m_q[k][c] = '0; m_dirty[k][c] = 1'b0; m_qp[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_step(input int k);
        logic         hs;
        logic [W-1:0] dv, v;
        hs = CV && (m_hold[k] == 0);
        for (int c = 0; c < CH; c++) begin
            dv = D[c*W +: W];
            if (hs && !MODE) begin
                if (m_dirty[k][c] || E[c]) begin
                    v = E[c] ? dv : m_stg[k][c];
                    m_q[k][c] = v;
                    m_qp[k][c] = ^v;
                end
                m_dirty[k][c] = 1'b0;
            end else if (E[c]) begin
                if (MODE) begin
                    m_q[k][c] = dv; m_qp[k][c] = ^dv; m_dirty[k][c] = 1'b0;
                end else begin
                    m_dirty[k][c] = 1'b1;
                end
            end
            if (E[c]) m_stg[k][c] = dv;
        end
        if (hs) m_hold[k] = m_holdoff[k];
        else if (m_hold[k] > 0) m_hold[k] = m_hold[k] - 1;
    endtask

    function automatic logic [NB-1:0] m_qvec(input int k);
        logic [NB-1:0] r;
        for (int c = 0; c < CH; c++) r[c*W +: W] = m_q[k][c];
        return r;
    endfunction

    function automatic logic [CH-1:0] m_dvec(input int k);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_dirty[k][c];
        return r;
    endfunction

    function automatic logic [CH-1:0] m_pvec(input int k);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_qp[k][c];
        return r;
    endfunction

    initial model_reset();

    // Model advances on every active edge out of reset; async reset clears it at once.
    always @(posedge CLK) begin
        if (RN === 1'b1) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge RN) model_reset();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare of both DUTs against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("model_q_a", 32'(q_a), 32'(m_qvec(0)));
        chk("model_dirty_a", 32'(dirty_a), 32'(m_dvec(0)));
        chk("model_rdy_a", 32'(rdy_a), 32'(m_hold[0] == 0));
        chk("model_q_b", 32'(q_b), 32'(m_qvec(1)));
        chk("model_dirty_b", 32'(dirty_b), 32'(m_dvec(1)));
        chk("model_rdy_b", 32'(rdy_b), 32'(m_hold[1] == 0));
`ifdef LATRNQ_BANK_PARITY_EN
        chk("model_qp_a", 32'(qp_a), 32'(m_pvec(0)));
        chk("model_qp_b", 32'(qp_b), 32'(m_pvec(1)));
`endif
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RN = 1'b0; D = '0; E = '0; MODE = 1'b0; CV = 1'b0;
        tick(); tick();
        chk("rst_q", 32'(q_a), 32'h0);
        chk("rst_dirty", 32'(dirty_a), 32'h0);
        chk("rst_rdy", 32'(rdy_a), 32'h1);
        RN = 1'b1;
        tick();

        // Staged writes to ch0 and ch2, then commit.
        E = 4'b0101; D = 32'h003C_00A5;
        tick();
        E = '0;
        chk("stage_dirty", 32'(dirty_a), 32'h5);
        chk("stage_q_hold", 32'(q_a), 32'h0);
        CV = 1'b1;
        tick();
        CV = 1'b0;
        chk("commit_q", 32'(q_a), 32'h003C_00A5);
        chk("commit_dirty", 32'(dirty_a), 32'h0);
        chk("hold_rdy1", 32'(rdy_a), 32'h0);
        chk("h0_rdy", 32'(rdy_b), 32'h1);
        tick();
        chk("hold_rdy2", 32'(rdy_a), 32'h0);
        tick();
        chk("hold_rdy_back", 32'(rdy_a), 32'h1);

        // Same-cycle forward on ch1, commit valid then held through HOLD.
        E = 4'b0010; D = 32'h0000_1100;
        tick();
        chk("fwd_dirty", 32'(dirty_a), 32'h2);
        E = 4'b0010; D = 32'h0000_2200; CV = 1'b1;
        tick();
        E = '0;
        chk("fwd_q", 32'(q_a), 32'h003C_22A5);
        chk("fwd_dirty0", 32'(dirty_a), 32'h0);
        E = 4'b1000; D = 32'h7F00_0000;
        tick();
        E = '0;
        chk("holdwr_dirty", 32'(dirty_a), 32'h8);
        chk("holdwr_q", 32'(q_a), 32'h003C_22A5);
        chk("holdwr_rdy", 32'(rdy_a), 32'h0);
        tick();
        chk("held_noc_q", 32'(q_a), 32'h003C_22A5);
        chk("held_rdy", 32'(rdy_a), 32'h1);
        tick();
        CV = 1'b0;
        chk("second_q", 32'(q_a), 32'h7F3C_22A5);
        chk("second_dirty", 32'(dirty_a), 32'h0);
        tick(); tick();

        // Staged dirty ch0 survives switch to transparent; transparent write ch2.
        E = 4'b0001; D = 32'h0000_0055;
        tick();
        MODE = 1'b1; E = 4'b0100; D = 32'h00FF_0000;
        tick();
        E = '0;
        chk("transp_q", 32'(q_a), 32'h7FFF_22A5);
        chk("transp_dirty", 32'(dirty_a), 32'h1);
        CV = 1'b1;
        tick();
        CV = 1'b0;
        chk("transp_commit_q", 32'(q_a), 32'h7FFF_22A5);
        chk("transp_commit_dirty", 32'(dirty_a), 32'h1);
        chk("transp_commit_rdy", 32'(rdy_a), 32'h0);
        tick(); tick();
        MODE = 1'b0; CV = 1'b1;
        tick();
        CV = 1'b0;
        chk("staged_after_q", 32'(q_a), 32'h7FFF_2255);
        tick(); tick();

        // Parity of published values.
        E = 4'b0001; D = 32'h0000_0007; CV = 1'b1;
        tick();
        E = '0; CV = 1'b0;
        chk("par7_q", 32'(q_a[7:0]), 32'h07);
`ifdef LATRNQ_BANK_PARITY_EN
        chk("par7_qp", 32'(qp_a[0]), 32'h1);
`endif
        tick(); tick();
        E = 4'b0001; D = 32'h0000_0003; CV = 1'b1;
        tick();
        E = '0; CV = 1'b0;
        chk("par3_q", 32'(q_a[7:0]), 32'h03);
`ifdef LATRNQ_BANK_PARITY_EN
        chk("par3_qp", 32'(qp_a[0]), 32'h0);
`endif
        tick(); tick();

        // Back-to-back commits: accepted by HOLDOFF=0 bank, second staged in the HOLDOFF=2 bank.
        E = 4'b0001; D = 32'h0000_0012; CV = 1'b1;
        tick();
        chk("b2b1_q0", 32'(q_b[7:0]), 32'h12);
        chk("b2b1_q2", 32'(q_a[7:0]), 32'h12);
        D = 32'h0000_0034;
        tick();
        E = '0; CV = 1'b0;
        chk("b2b2_q0", 32'(q_b[7:0]), 32'h34);
        chk("b2b2_rdy0", 32'(rdy_b), 32'h1);
        chk("b2b2_q2", 32'(q_a[7:0]), 32'h12);
        chk("b2b2_dirty2", 32'(dirty_a), 32'h1);
        tick(); tick();

        // Reset asserted mid-HOLD with Q nonzero.
        CV = 1'b1;
        tick();
        CV = 1'b0;
        chk("prerst_rdy", 32'(rdy_a), 32'h0);
        #3 RN = 1'b0;
        #1;
        chk("midrst_q", 32'(q_a), 32'h0);
        chk("midrst_dirty", 32'(dirty_a), 32'h0);
        chk("midrst_rdy", 32'(rdy_a), 32'h1);
        tick();
        RN = 1'b1;
        tick(); tick();
        chk("postrst_q", 32'(q_a), 32'h0);
        chk("postrst_rdy", 32'(rdy_a), 32'h1);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                RN = 1'b0;
                tick();
                RN = 1'b1;
            end
            E    = CH'($urandom);
            D    = NB'($urandom);
            MODE = ($urandom_range(0, 3) == 0);
            CV   = ($urandom_range(0, 2) == 0);
            tick();
        end
        E = '0; CV = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
